// File: rtl/icache_pkg.sv
// icache_pkg: I-cache geometry shared by fetch_lookup and result_drive, plus PC field extraction.
package icache_pkg;
  localparam int TAG_W    = 24;
  localparam int INDEX_W  = 4;
  localparam int OFFSET_W = 4;
  localparam int WAYS     = 8;
  localparam int LINE_W   = 128;

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
    return pc[31:INDEX_W+OFFSET_W];
  endfunction

  function automatic logic [INDEX_W-1:0] pc_index(input logic [31:0] pc);
    return pc[INDEX_W+OFFSET_W-1:OFFSET_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] pc_offset(input logic [31:0] pc);
    return pc[OFFSET_W-1:0];
  endfunction
endpackage

// File: rtl/icache_way.sv
// icache_way: one way of valid/tag/data storage with a write port and combinational read/compare.
module icache_way
  import icache_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int LINE_W = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wen_i,
  input  logic [INDEX_W-1:0] windex_i,
  input  logic [TAG_W-1:0]   wtag_i,
  input  logic [LINE_W-1:0]  wdata_i,
  input  logic [INDEX_W-1:0] rindex_i,
  input  logic [TAG_W-1:0]   rtag_i,
  output logic               hit_o,
  output logic [LINE_W-1:0]  data_o
);
  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [LINE_W-1:0] r_data [SETS];

  always_ff @(posedge clock or posedge reset)
    if (reset) r_valid <= '0;
    else if (wen_i) r_valid[windex_i] <= 1'b1;

  // tag/data need no reset: they are masked by r_valid until first written
  always_ff @(posedge clock)
    if (wen_i) begin
      r_tag[windex_i]  <= wtag_i;
      r_data[windex_i] <= wdata_i;
    end

  assign hit_o  = r_valid[rindex_i] && r_tag[rindex_i] == rtag_i;
  assign data_o = r_data[rindex_i];
endmodule

// File: rtl/fetch_lookup.sv
// fetch_lookup: I-cache tag-lookup stage (8-way, 16-set, 16-byte lines) with fill forwarding.
// Define ICACHE_PERF_EN to add the perf_access_o/perf_hit_o counters.
module fetch_lookup
  import icache_pkg::*;
#(
  parameter int WAYS   = 8,
  parameter int SETS   = 16,
  parameter int LINE_W = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               valid_pre_i,
  output logic               ready_pre_o,
  input  logic [31:0]        pc_i,
  output logic               valid_post_o,
  input  logic               ready_post_i,
  output logic               tar_hit_o,
  output logic [31:0]        araddr_o,
  output logic [LINE_W-1:0]  buffer_o,
  input  logic               flush_i,
  input  logic               wen_i,
  input  logic [INDEX_W-1:0] windex_i,
  input  logic [2:0]         wway_i,
  input  logic [TAG_W-1:0]   wtag_i,
  input  logic [LINE_W-1:0]  wdata_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]        perf_access_o,
  output logic [31:0]        perf_hit_o
`endif
);
  logic               r_valid;
  logic [31:0]        r_pc;
  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_index;
  logic [WAYS-1:0]    w_way_hit;
  logic [LINE_W-1:0]  w_way_data [WAYS];
  logic               w_arr_hit;
  logic [LINE_W-1:0]  w_arr_line;
  logic               w_fwd;

  assign ready_pre_o  = !r_valid || ready_post_i;
  assign valid_post_o = r_valid;
  assign araddr_o     = r_pc;
  assign w_tag        = pc_tag(r_pc);
  assign w_index      = pc_index(r_pc);

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
    end else if (flush_i) r_valid <= 1'b0;
    else if (valid_pre_i && ready_pre_o) begin
      r_valid <= 1'b1;
      r_pc    <= pc_i;
    end else if (ready_post_i) r_valid <= 1'b0;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(.SETS(SETS), .LINE_W(LINE_W)) u_way (
      .clock   (clock),
      .reset   (reset),
      .wen_i   (wen_i && wway_i == 3'(w)),
      .windex_i(windex_i),
      .wtag_i  (wtag_i),
      .wdata_i (wdata_i),
      .rindex_i(w_index),
      .rtag_i  (w_tag),
      .hit_o   (w_way_hit[w]),
      .data_o  (w_way_data[w])
    );
  end

  // scanning downward lets the lowest hitting way win
  always_comb begin
    w_arr_hit  = 1'b0;
    w_arr_line = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (w_way_hit[i]) begin
        w_arr_hit  = 1'b1;
        w_arr_line = w_way_data[i];
      end
  end

  // an in-flight fill of the held line counts as a hit, avoiding a duplicate miss
  assign w_fwd     = wen_i && windex_i == w_index && wtag_i == w_tag;
  assign tar_hit_o = r_valid && (w_fwd || w_arr_hit);
  assign buffer_o  = !tar_hit_o ? '0 : w_fwd ? wdata_i : w_arr_line;

`ifdef ICACHE_PERF_EN
  logic [31:0] r_perf_access;
  logic [31:0] r_perf_hit;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_perf_access <= '0;
      r_perf_hit    <= '0;
    end else if (valid_post_o && ready_post_i) begin
      r_perf_access <= r_perf_access + 32'd1;
      r_perf_hit    <= r_perf_hit + 32'(tar_hit_o);
    end

  assign perf_access_o = r_perf_access;
  assign perf_hit_o    = r_perf_hit;
`endif
endmodule

// File: doc/fetch_lookup.md
# fetch_lookup

Instruction-cache tag-lookup stage of the fetch unit. Sits between the PC generator and `result_drive`. Owns the tag, valid and data arrays of the 8-way, 16-set, 16-byte-line instruction cache. Each cycle it registers one PC, resolves hit/miss, and hands `{araddr, hit, line}` downstream. It also absorbs line fills written back by `result_drive`.

## Interface
- `WAYS`, default 8: associativity. Fixed; the way select is 3 bits.
- `SETS`, default 16: sets per way. Fixed; the index is 4 bits.
- `LINE_W`, default 128: line width in bits.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `valid_pre_i` in 1: PC generator offers `pc_i`.
- `ready_pre_o` out 1: this stage accepts `pc_i`.
- `pc_i` in 32: fetch address, word aligned.
- `valid_post_o` out 1: lookup result is valid toward `result_drive`.
- `ready_post_i` in 1: `result_drive` accepts the result.
- `tar_hit_o` out 1: the line is present.
- `araddr_o` out 32: held PC.
- `buffer_o` out 128: hit line data; 0 on a miss.
- `flush_i` in 1: taken-branch redirect; kills the held entry.
- `wen_i` in 1: fill write from `result_drive`.
- `windex_i` in 4: set index of the fill.
- `wway_i` in 3: way of the fill.
- `wtag_i` in 24: tag of the fill.
- `wdata_i` in 128: line data of the fill.

## Operation
- Address split: tag = pc[31:8], index = pc[7:4], offset = pc[3:0].
- Holding register: `valid_q`, `pc_q`.
- `ready_pre_o = !valid_q || ready_post_i`.
- `valid_post_o = valid_q`.
- `araddr_o = pc_q`.
- On accept (`valid_pre_i && ready_pre_o`): `pc_q <= pc_i`, `valid_q <= 1`.
- When downstream takes the entry and nothing new arrives: `valid_q <= 0`.
- Hit is recomputed combinationally every cycle from live array contents at `pc_q`. A held entry therefore sees fills that land while it waits.
- Way hit condition: `valid[way][index] && tag[way][index] == tag`.
- If several ways hit, the lowest way index wins.
- Fill forwarding: if `wen_i && windex_i == index && wtag_i == tag` in the same cycle, `tar_hit_o = 1` and `buffer_o = wdata_i`. This overrides the array hit and prevents a duplicate miss for a line being filled.
- Fill write: on `wen_i`, `tag[wway_i][windex_i] <= wtag_i`, `data <= wdata_i`, `valid <= 1`. The write is unconditional and independent of the handshakes.
- Flush: on `flush_i`, `valid_q <= 0` and any same-cycle upstream offer is dropped. Flush has priority over accept.
- Flush does not touch the arrays.
- The held entry is stable while `valid_post_o && !ready_post_i`: `pc_q` is frozen, but hit/data may change from miss to hit via a fill.

## Timing
- Reset values: `valid_q = 0`, `pc_q = 0`, all valid bits 0. Resulting outputs: `valid_post_o = 0`, `tar_hit_o = 0`, `araddr_o = 0`, `buffer_o = 0`, `ready_pre_o = 1`.
- Tag and data arrays are not reset. They are never observed while their valid bit is 0.
- Reset asserted mid-operation discards the held entry and invalidates the whole cache immediately, without waiting for a clock edge.
- Latency: PC accepted at edge N; result valid from cycle N+1.
- Throughput: 1 per cycle when `ready_post_i` is held high.
- A fill at edge N is visible to array lookups in cycle N+1. During cycle N the same line is covered by forwarding.

## Configuration
- `ICACHE_PERF_EN` defined:
  - Adds outputs `perf_access_o[31:0]` and `perf_hit_o[31:0]`.
  - `perf_access_o` increments on each post handshake; `perf_hit_o` increments on each post handshake with `tar_hit_o = 1`.
  - Both reset to 0 and wrap modulo 2^32.
- `ICACHE_PERF_EN` undefined: the counters and their ports are absent; behaviour is otherwise identical.

## Structure
- `icache_pkg` holds `TAG_W = 24`, `INDEX_W = 4`, `OFFSET_W = 4`, `WAYS = 8`, `LINE_W = 128`, and the tag/index/offset field extraction. `result_drive` uses the same package.
- One sub-module, `icache_way`: one way's valid, tag and data storage, with a write port and a combinational read/compare. `fetch_lookup` instantiates it 8 times, followed by a priority select.

## Test plan
- Cold miss: after reset, offer pc 0x8000_0000 -> next cycle `valid_post_o = 1`, `tar_hit_o = 0`, `araddr_o = 0x8000_0000`, `buffer_o = 0`.
- Fill then hit: `wen_i` with index 0, way 5, tag 0x800000, data D; then offer pc 0x8000_0008 -> `tar_hit_o = 1`, `buffer_o = D`.
- Forwarding: hold pc 0x8000_0010 with `ready_post_i = 0`; pulse `wen_i` with index 1, tag 0x800000 -> `tar_hit_o = 1` in that same cycle, and still 1 after the pulse.
- Backpressure: `ready_post_i = 0` for 5 cycles -> `ready_pre_o = 0`, `araddr_o` stable, no PC lost. Release -> back-to-back results at 1 per cycle.
- Flush priority: `flush_i = 1` together with `valid_pre_i = 1` -> next cycle `valid_post_o = 0`, and the offered PC is not accepted.
- Async reset: assert `reset` between clock edges with the entry held -> `valid_post_o` falls immediately; a prior hit line now misses. With `ICACHE_PERF_EN` defined, the counters read 0.
